// File: rtl/sopc_video_st_packet_arbiter.sv
// Two-input Avalon-ST packet arbiter.
// Packets from two sinks are merged onto one registered source. Each grant
// covers a whole packet, so beats of different packets never interleave.
// Ties between two waiting start-of-packet beats are broken round robin.
// Beats that arrive outside a packet while idle are consumed and counted
// in a saturating drop counter.
module sopc_video_st_packet_arbiter #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned DROP_CNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,

  input  logic                      in0_valid,
  input  logic                      in0_startofpacket,
  input  logic                      in0_endofpacket,
  input  logic                      in0_empty,
  input  logic [DATA_WIDTH-1:0]     in0_data,
  output logic                      in0_ready,

  input  logic                      in1_valid,
  input  logic                      in1_startofpacket,
  input  logic                      in1_endofpacket,
  input  logic                      in1_empty,
  input  logic [DATA_WIDTH-1:0]     in1_data,
  output logic                      in1_ready,

  input  logic                      out_ready,
  output logic                      out_valid,
  output logic                      out_startofpacket,
  output logic                      out_endofpacket,
  output logic                      out_empty,
  output logic [DATA_WIDTH-1:0]     out_data,

  output logic                      busy,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic                      last_grant_q, last_grant_d;

  logic                      out_valid_q, out_valid_d;
  logic                      out_sop_q, out_sop_d;
  logic                      out_eop_q, out_eop_d;
  logic                      out_empty_q, out_empty_d;
  logic [DATA_WIDTH-1:0]     out_data_q, out_data_d;

  logic [DROP_CNT_WIDTH-1:0] drop_count_q, drop_count_d;

  // Beat selected from the locked input and whether it moves this cycle
  logic                      ld;
  logic                      xfer;
  logic                      x_sop;
  logic                      x_eop;
  logic                      x_empty;
  logic [DATA_WIDTH-1:0]     x_data;

  logic                      cand0, cand1;
  logic                      drop0, drop1;
  logic [1:0]                drop_inc;
  logic [DROP_CNT_WIDTH:0]   drop_sum;

  // Output register may accept a new beat when empty or being drained
  assign ld = !out_valid_q || out_ready;

  assign cand0 = in0_valid && in0_startofpacket;
  assign cand1 = in1_valid && in1_startofpacket;

  // Arbitration, packet locking and per-input backpressure
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    in0_ready    = 1'b0;
    in1_ready    = 1'b0;
    xfer         = 1'b0;
    x_sop        = in0_startofpacket;
    x_eop        = in0_endofpacket;
    x_empty      = in0_empty;
    x_data       = in0_data;
    drop0        = 1'b0;
    drop1        = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Out-of-packet beats are swallowed; pending SOP beats wait
        drop0     = in0_valid && !in0_startofpacket;
        drop1     = in1_valid && !in1_startofpacket;
        in0_ready = drop0;
        in1_ready = drop1;
        if (cand0 && cand1) begin
          if (last_grant_q) begin
            state_d      = LOCK0;
            last_grant_d = 1'b0;
          end else begin
            state_d      = LOCK1;
            last_grant_d = 1'b1;
          end
        end else if (cand0) begin
          state_d      = LOCK0;
          last_grant_d = 1'b0;
        end else if (cand1) begin
          state_d      = LOCK1;
          last_grant_d = 1'b1;
        end
      end
      LOCK0: begin
        in0_ready = ld;
        xfer      = in0_valid && ld;
        if (xfer && in0_endofpacket) begin
          state_d = IDLE;
        end
      end
      LOCK1: begin
        in1_ready = ld;
        xfer      = in1_valid && ld;
        x_sop     = in1_startofpacket;
        x_eop     = in1_endofpacket;
        x_empty   = in1_empty;
        x_data    = in1_data;
        if (xfer && in1_endofpacket) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // No beat is accepted from either sink while reset is held
    if (reset) begin
      in0_ready = 1'b0;
      in1_ready = 1'b0;
      drop0     = 1'b0;
      drop1     = 1'b0;
    end
  end

  // Registered source stage: load on transfer, drain when ld without data
  always_comb begin
    out_valid_d = out_valid_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_empty_d = out_empty_q;
    out_data_d  = out_data_q;
    if (ld) begin
      if (xfer) begin
        out_valid_d = 1'b1;
        out_sop_d   = x_sop;
        out_eop_d   = x_eop;
        out_empty_d = x_empty;
        out_data_d  = x_data;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // Saturating drop counter; both sinks may drop in the same cycle
  always_comb begin
    drop_inc     = {1'b0, drop0} + {1'b0, drop1};
    drop_sum     = {1'b0, drop_count_q} + (DROP_CNT_WIDTH + 1)'(drop_inc);
    drop_count_d = drop_sum[DROP_CNT_WIDTH-1:0];
    if (drop_sum[DROP_CNT_WIDTH]) begin
      drop_count_d = '1;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      out_valid_q  <= 1'b0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      out_empty_q  <= 1'b0;
      out_data_q   <= '0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      out_valid_q  <= out_valid_d;
      out_sop_q    <= out_sop_d;
      out_eop_q    <= out_eop_d;
      out_empty_q  <= out_empty_d;
      out_data_q   <= out_data_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign busy              = (state_q != IDLE);
  assign out_valid         = out_valid_q;
  assign out_startofpacket = out_sop_q;
  assign out_endofpacket   = out_eop_q;
  assign out_empty         = out_empty_q;
  assign out_data          = out_data_q;
  assign drop_count        = drop_count_q;

endmodule
